soc_system_pio_edge_in: RTL and testbench

Avalon-MM slave input PIO that returns FPGA-side status (memory-controller done/busy flags, pixel-engine status) to the HPS; the read-back counterpart of the write-only output PIOs in `soc_system`. It:
- synchronizes `in_port` into `clk`;
- detects per-bit edges under a software-selected mode;
- latches edges into a sticky, write-1-to-clear capture register;
- raises a level interrupt through a per-bit mask.

---
 rtl/soc_pio_pkg.sv | 20 ++
 rtl/soc_system_pio_edge_in_if.sv | 23 ++
 rtl/soc_system_pio_edge_in_sync_edge.sv | 51 +++++
 rtl/soc_system_pio_edge_in.sv | 122 ++++++++++++
 tb/tb_soc_system_pio_edge_in.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/soc_pio_pkg.sv
// Purpose: shared register offsets and edge-mode encodings for the input PIOs.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package soc_pio_pkg;

  // Word offsets within the slave.
  localparam logic [1:0] REG_DATA      = 2'd0;
  localparam logic [1:0] REG_EDGE_MODE = 2'd1;
  localparam logic [1:0] REG_IRQ_MASK  = 2'd2;
  localparam logic [1:0] REG_EDGE_CAP  = 2'd3;

  // Which input transitions count as a hit.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_ANY  = 2'b11
  } edge_mode_e;

endpackage

// File: rtl/soc_system_pio_edge_in_if.sv
// Purpose: Avalon-MM slave bus bundle (address, strobes, data) for the PIOs.
// Latency: n/a (wiring only); readdata is driven registered by the slave.
// Backpressure: none, no waitrequest; the slave accepts an access every cycle.
// Ports: address[1:0], chipselect, read_n, write_n, writedata[31:0] (master
//        to slave); readdata[31:0] (slave to master).
interface soc_system_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_pio_edge_in_sync_edge.sv
// Purpose: multi-flop synchronizer plus one delay flop giving per-bit rise/fall.
// Latency: din reaches sync after SYNC_STAGES edges; rise/fall are combinational from sync.
// Backpressure: none, free-running every cycle.
// Ports: clk, reset_n (sync, active-low), din[WIDTH-1:0] (async),
//        sync/rise/fall[WIDTH-1:0].
module pio_sync_edge #(
  parameter int WIDTH       = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] stage_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d_q;
  logic [WIDTH-1:0] sync_d_d;

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    sync_d_d = stage_q[SYNC_STAGES-1];
  end

  // The delay flop resets to 0 too, so an input already high when reset
  // releases shows up as one rising edge once it reaches sync.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      sync_d_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
      sync_d_q <= sync_d_d;
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = sync & ~sync_d_q;
  assign fall = ~sync & sync_d_q;

endmodule

// File: rtl/soc_system_pio_edge_in.sv
// Purpose: Avalon-MM input PIO with edge capture (W1C), per-bit irq mask and level irq.
// Latency: read data 1 cycle after strobe; input to capture/irq SYNC_STAGES+1 edges.
// Backpressure: none, accepts a read and/or write every cycle.
// Ports: clk, reset_n (sync, active-low), avs (Avalon slave bundle),
//        irq (registered level), in_port[WIDTH-1:0] (async status inputs).
module soc_system_pio_edge_in
  import soc_pio_pkg::*;
#(
  parameter int WIDTH       = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  soc_system_pio_edge_in_if.slave  avs,
  output logic                     irq,
  input  logic [WIDTH-1:0]         in_port
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .sync    (sync),
    .rise    (rise),
    .fall    (fall)
  );

  edge_mode_e       mode_q,     mode_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] capture_q,  capture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q,      irq_d;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;

  assign wr_en = avs.chipselect & ~avs.write_n;
  assign rd_en = avs.chipselect & ~avs.read_n;

  always_comb begin
    hit = '0;
    case (mode_q)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = fall;
      EDGE_ANY:  hit = rise | fall;
      default:   hit = '0;
    endcase
  end

  // Clear is applied before OR-ing in the hit so a same-cycle hit survives.
  always_comb begin
    clr = '0;
    if (wr_en && (avs.address == REG_EDGE_CAP)) begin
      clr = avs.writedata[WIDTH-1:0];
    end
    capture_d = (capture_q & ~clr) | hit;
  end

  always_comb begin
    mode_d     = mode_q;
    irq_mask_d = irq_mask_q;
    if (wr_en && (avs.address == REG_EDGE_MODE)) begin
      mode_d = edge_mode_e'(avs.writedata[1:0]);
    end
    if (wr_en && (avs.address == REG_IRQ_MASK)) begin
      irq_mask_d = avs.writedata[WIDTH-1:0];
    end
  end

  // Computed from next-state values so a clear or mask write moves irq on
  // the same edge that commits it.
  assign irq_d = |(capture_d & irq_mask_d);

  // Reads see the current (pre-write) registers.
  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      case (avs.address)
        REG_DATA:      readdata_d = 32'(sync);
        REG_EDGE_MODE: readdata_d = 32'(mode_q);
        REG_IRQ_MASK:  readdata_d = 32'(irq_mask_q);
        REG_EDGE_CAP:  readdata_d = 32'(capture_q);
        default:       readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q     <= EDGE_RISE;
      irq_mask_q <= '0;
      capture_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      irq_mask_q <= irq_mask_d;
      capture_q  <= capture_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;

  // Upper writedata bits carry no register content.
  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wd;
    assign unused_wd = ^avs.writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_soc_system_pio_edge_in.sv
module tb_soc_system_pio_edge_in;
  localparam int W  = 17;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic         irq;

  soc_system_pio_edge_in_if bus ();

  soc_system_pio_edge_in #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .avs     (bus),
    .irq     (irq),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  // inhist[k] = in_port as sampled k+1 edges ago (index 0 = newest).
  logic [W-1:0] inhist[$];
  logic [W-1:0] m_cap, m_mask;
  logic [1:0]   m_mode;
  logic [31:0]  m_rdata;
  logic         m_irq;
  bit           m_valid = 0;

  always @(posedge clk) begin : model
    logic [W-1:0] s, sd, hit, clr;
    logic [31:0]  rv;
    if (!reset_n) begin
      inhist.delete();
      for (int k = 0; k <= SS; k++) inhist.push_back('0);
      m_cap = '0; m_mask = '0; m_mode = 2'b01; m_rdata = '0; m_irq = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      s  = inhist[SS-1];   // synchronized value seen this cycle
      sd = inhist[SS];     // synchronized value one cycle earlier
      case (m_mode)
        2'b01:   hit = s & ~sd;
        2'b10:   hit = sd & ~s;
        2'b11:   hit = s ^ sd;
        default: hit = '0;
      endcase
      case (bus.address)
        2'd0:    rv = {{(32-W){1'b0}}, s};
        2'd1:    rv = {30'd0, m_mode};
        2'd2:    rv = {{(32-W){1'b0}}, m_mask};
        default: rv = {{(32-W){1'b0}}, m_cap};
      endcase
      if (bus.chipselect && !bus.read_n) m_rdata = rv;
      clr = '0;
      if (bus.chipselect && !bus.write_n) begin
        if (bus.address == 2'd3) clr = bus.writedata[W-1:0];
        if (bus.address == 2'd1) m_mode = bus.writedata[1:0];
        if (bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
      end
      m_cap = (m_cap & ~clr) | hit;
      m_irq = (m_cap & m_mask) != '0;
      inhist.push_front(in_port);
      void'(inhist.pop_back());
    end
  end

  // Every-cycle comparison of outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_readdata", bus.readdata, m_rdata);
      check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // ---------------- bus tasks (called at a negedge, return at a negedge) ----------------
  task automatic bus_idle();
    bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1;
    bus.address = 2'd0; bus.writedata = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.read_n = 1'b1;
    bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.read_n = 1'b0;
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
    bus_idle();
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    bus_idle();
    reset_n = 1'b0;
    in_port = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset defaults
    read_check("rst_data", 2'd0, 32'h0);
    read_check("rst_mode", 2'd1, 32'h1);
    read_check("rst_mask", 2'd2, 32'h0);
    read_check("rst_cap",  2'd3, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);

    // Rising-edge capture: irq exactly 3 edges after the input change
    bus_write(2'd2, 32'h1);
    in_port[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("rise_irq_e2", {31'd0, irq}, 32'h0);
    @(negedge clk);
    check("rise_irq_e3", {31'd0, irq}, 32'h1);
    read_check("rise_cap",  2'd3, 32'h1);
    read_check("rise_data", 2'd0, 32'h1);

    // Collision: new hit on bit 0 in the same cycle as its clear
    in_port[0] = 1'b0;
    idle(4);
    in_port[0] = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(2'd3, 32'h1);
    check("coll_irq", {31'd0, irq}, 32'h1);
    read_check("coll_cap", 2'd3, 32'h1);
    bus_write(2'd3, 32'h1);
    check("coll_clr_irq", {31'd0, irq}, 32'h0);

    // Falling mode with bit masked off, then unmask
    in_port[5] = 1'b1;
    idle(5);
    bus_write(2'd3, 32'h1FFFF);
    bus_write(2'd1, 32'h2);
    bus_write(2'd2, 32'h0);
    in_port[5] = 1'b0;
    idle(5);
    read_check("fall_cap", 2'd3, 32'h20);
    check("fall_irq_masked", {31'd0, irq}, 32'h0);
    bus_write(2'd2, 32'h20);
    check("fall_irq_unmask", {31'd0, irq}, 32'h1);

    // Write-1-to-clear
    bus_write(2'd1, 32'h1);
    bus_write(2'd2, 32'h3);
    bus_write(2'd3, 32'h1FFFF);
    in_port[1:0] = 2'b00;
    idle(5);
    in_port[1:0] = 2'b11;
    idle(5);
    read_check("w1c_cap3", 2'd3, 32'h3);
    bus_write(2'd3, 32'h1);
    check("w1c_irq_hold", {31'd0, irq}, 32'h1);
    read_check("w1c_cap2", 2'd3, 32'h2);
    bus_write(2'd3, 32'h2);
    check("w1c_irq_fall", {31'd0, irq}, 32'h0);
    read_check("w1c_cap0", 2'd3, 32'h0);

    // Address-0 write ignored, mode change keeps capture
    bus_write(2'd0, 32'hFFFFFFFF);
    read_check("wr0_mode", 2'd1, 32'h1);

    // All bits captured, read+clear same cycle, then reset mid-operation
    in_port = '0;
    idle(5);
    bus_write(2'd3, 32'h1FFFF);
    bus_write(2'd2, 32'h1FFFF);
    in_port = '1;
    idle(5);
    read_check("full_cap", 2'd3, 32'h1FFFF);
    check("full_irq", {31'd0, irq}, 32'h1);
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.write_n = 1'b0;
    bus.address = 2'd3; bus.writedata = 32'h1;
    @(negedge clk);
    bus_idle();
    check("rdclr_preval", bus.readdata, 32'h1FFFF);
    read_check("rdclr_after", 2'd3, 32'h1FFFE);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_irq", {31'd0, irq}, 32'h0);
    check("mid_rst_rdata", bus.readdata, 32'h0);
    read_check("mid_rst_mode", 2'd1, 32'h1);
    read_check("mid_rst_mask", 2'd2, 32'h0);
    idle(5);
    read_check("mid_rst_recap", 2'd3, 32'h1FFFF);
    check("mid_rst_irq2", {31'd0, irq}, 32'h0);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'($urandom);
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.read_n     = $urandom_range(0, 1) == 0;
      bus.write_n    = $urandom_range(0, 2) != 0;
      bus.address    = 2'($urandom_range(0, 3));
      bus.writedata  = $urandom;
      @(negedge clk);
    end
    bus_idle();
    reset_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
